// File: rtl/mem_responder.sv
// Word-organised memory responder with valid/ready request and response handshakes.
// A request is accepted in IDLE, waits LATENCY posedges, then the response is held until taken.
// Optional feature: define MEM_RESPONDER_MMIO_EN to map a read-only free-running cycle counter
// at the word just past the array (BASE_ADDR + 4*DEPTH_WORDS).
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LatInit   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]     off;
  logic [IdxW-1:0] idx;
  logic            misaligned;
  logic            in_range;
  logic            mmio_hit;
  logic            err;
  logic            commit;
  logic            mem_wr;
  logic [31:0]     rdata_sel;

`ifdef MEM_RESPONDER_MMIO_EN
  logic [31:0] cyc_q;

  // Free-running cycle counter, readable through the MMIO word
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`endif

  // Address decode of the latched request; the subtraction wraps so low addresses fall out of range
  always_comb begin
    off        = addr_q - BASE_ADDR;
    idx        = off[IdxW+1:2];
    misaligned = |addr_q[1:0];
    in_range   = off < SpanBytes;
`ifdef MEM_RESPONDER_MMIO_EN
    mmio_hit   = !misaligned && (off == SpanBytes);
`else
    mmio_hit   = 1'b0;
`endif
    err        = misaligned || !(in_range || mmio_hit);
    commit     = (state_q == StBusy) && (cnt_q == 4'd0);
    // The array is only touched on the edge entering RESP, and never while in reset
    mem_wr     = commit && we_q && !err && !mmio_hit && reset;
  end

  // Response data selection; writes and errors return zero
  always_comb begin
    rdata_sel = '0;
    if (!err && !we_q) begin
`ifdef MEM_RESPONDER_MMIO_EN
      // Counter value as it becomes on the RESP-entry edge
      if (mmio_hit) begin
        rdata_sel = cyc_q + 32'd1;
      end else begin
        rdata_sel = mem[idx];
      end
`else
      rdata_sel = mem[idx];
`endif
    end
  end

  // Request/response FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            wstrb_q <= req_wstrb;
            cnt_q   <= LatInit;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_sel;
            rsp_err_q   <= err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte-masked array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
